// File: rtl/shared_counters_sched_if.sv
// Requester-side bus of shared_counters_sched: flattened per-client request
// payloads plus the grant and response signals returned to the clients.
interface shared_counters_sched_if #(
  parameter int N    = 10,
  parameter int G    = 4,
  parameter int NREQ = 4
);
  localparam int IW = $clog2(N);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [3*NREQ-1:0]      req_cmd;
  logic [IW*NREQ-1:0]     req_id;
  logic [(IW+1)*NREQ-1:0] req_size;
  logic [64*NREQ-1:0]     req_load_data;

  logic [NREQ-1:0]        gnt;
  logic                   rsp_valid;
  logic [OW-1:0]          rsp_owner;
  logic                   rsp_ok;
  logic [IW:0]            rsp_alloc_id;
  logic [G-1:0]           rsp_rdata;
  logic                   rsp_rdata_valid;
  logic                   rsp_rdata_last;

  modport master (
    output req, req_cmd, req_id, req_size, req_load_data,
    input  gnt, rsp_valid, rsp_owner, rsp_ok, rsp_alloc_id,
           rsp_rdata, rsp_rdata_valid, rsp_rdata_last
  );

  modport slave (
    input  req, req_cmd, req_id, req_size, req_load_data,
    output gnt, rsp_valid, rsp_owner, rsp_ok, rsp_alloc_id,
           rsp_rdata, rsp_rdata_valid, rsp_rdata_last
  );
endinterface

// File: rtl/shared_counters_sched.sv
// Round-robin command scheduler in front of shared_counters: grants one client
// at a time, sequences the downstream command and returns a tagged response.
//
// state        | meaning
// S_IDLE       | no command in flight, arbitrate on any request
// S_ISSUE      | command driven to shared_counters, gnt pulsed
// S_WAIT_ALLOC | new issued, waiting for allocation id (bounded)
// S_WAIT_READ  | read issued, forwarding beats until last (bounded)
// S_GAP        | one idle cycle carrying the response, may arbitrate
module shared_counters_sched #(
  parameter int N          = 10,
  parameter int G          = 4,
  parameter int NREQ       = 4,
  parameter int ALLOC_WAIT = 8,
  parameter int READ_WAIT  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_counters_sched_if.slave req_if,
  output logic [2:0]           sc_command_in_o,
  output logic [$clog2(N)-1:0] sc_id_o,
  output logic [31:0]          sc_new_counter_size_o,
  output logic [63:0]          sc_load_data_in_o,
  output logic                 sc_valid_load_data_o,
  input  logic [$clog2(N):0]   sc_allocation_id_i,
  input  logic                 sc_valid_allocation_id_i,
  input  logic [G-1:0]         sc_rdata_out_i,
  input  logic                 sc_valid_data_out_i,
  input  logic                 sc_last_i
);
  localparam int IW   = $clog2(N);
  localparam int OW   = $clog2(NREQ);
  localparam int TMAX = (ALLOC_WAIT > READ_WAIT) ? ALLOC_WAIT : READ_WAIT;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [2:0] CMD_NONE    = 3'b000;
  localparam logic [2:0] CMD_INC     = 3'b001;
  localparam logic [2:0] CMD_NEW     = 3'b010;
  localparam logic [2:0] CMD_DEALLOC = 3'b011;
  localparam logic [2:0] CMD_LOAD    = 3'b100;
  localparam logic [2:0] CMD_READ    = 3'b101;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ALLOC, S_WAIT_READ, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [2:0]      cmd_q, cmd_d;
  logic            rej_q, rej_d;
  logic [CW-1:0]   tmr_q, tmr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            rsp_ok_q, rsp_ok_d;
  logic [IW:0]     alloc_q, alloc_d;
  logic [G-1:0]    rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            rlast_q, rlast_d;
  logic [2:0]      sc_cmd_q, sc_cmd_d;
  logic [IW-1:0]   sc_id_q, sc_id_d;
  logic [31:0]     sc_size_q, sc_size_d;
  logic [63:0]     sc_data_q, sc_data_d;
  logic            sc_vld_q, sc_vld_d;

  logic            win_found;
  logic [OW-1:0]   win, idx;
  logic [2:0]      w_cmd;
  logic [IW-1:0]   w_id;
  logic [IW:0]     w_size;
  logic [63:0]     w_data;
  logic            w_rej;

  // First asserted request at or after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = OW'((int'(ptr_q) + i) % NREQ);
      if (!win_found && req_if.req[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  assign w_cmd  = req_if.req_cmd[3*win +: 3];
  assign w_id   = req_if.req_id[IW*win +: IW];
  assign w_size = req_if.req_size[(IW+1)*win +: IW+1];
  assign w_data = req_if.req_load_data[64*win +: 64];
  assign w_rej  = !(w_cmd inside {CMD_INC, CMD_NEW, CMD_DEALLOC, CMD_LOAD, CMD_READ}) ||
                  (w_cmd == CMD_NEW && w_size == '0);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cmd_d       = cmd_q;
    rej_d       = rej_q;
    tmr_d       = tmr_q;
    owner_d     = owner_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_ok_d    = 1'b0;
    alloc_d     = '0;
    rdata_d     = '0;
    rvalid_d    = 1'b0;
    rlast_d     = 1'b0;
    sc_cmd_d    = CMD_NONE;
    sc_id_d     = '0;
    sc_size_d   = '0;
    sc_data_d   = '0;
    sc_vld_d    = 1'b0;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (win_found) begin
          state_d = S_ISSUE;
          ptr_d   = (win == OW'(NREQ - 1)) ? '0 : win + OW'(1);
          cmd_d   = w_cmd;
          rej_d   = w_rej;
          owner_d = win;
          gnt_d   = NREQ'(1) << win;
          if (!w_rej) begin
            sc_cmd_d = w_cmd;
            sc_id_d  = w_id;
            if (w_cmd == CMD_NEW) sc_size_d = 32'(w_size);
            if (w_cmd == CMD_LOAD) begin
              sc_data_d = w_data;
              sc_vld_d  = 1'b1;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (rej_q) begin
          state_d     = S_GAP;
          rsp_valid_d = 1'b1;
        end else if (cmd_q == CMD_NEW) begin
          // An allocation id returned in the issue cycle itself is accepted.
          if (sc_valid_allocation_id_i) begin
            state_d     = S_GAP;
            rsp_valid_d = 1'b1;
            rsp_ok_d    = 1'b1;
            alloc_d     = sc_allocation_id_i;
          end else begin
            state_d = S_WAIT_ALLOC;
            tmr_d   = CW'(ALLOC_WAIT);
          end
        end else if (cmd_q == CMD_READ) begin
          state_d  = S_WAIT_READ;
          tmr_d    = CW'(READ_WAIT);
          sc_cmd_d = CMD_READ;
          sc_id_d  = sc_id_q;
        end else begin
          state_d     = S_GAP;
          rsp_valid_d = 1'b1;
          rsp_ok_d    = 1'b1;
        end
      end
      S_WAIT_ALLOC: begin
        if (sc_valid_allocation_id_i) begin
          state_d     = S_GAP;
          rsp_valid_d = 1'b1;
          rsp_ok_d    = 1'b1;
          alloc_d     = sc_allocation_id_i;
        end else if (tmr_q == '0) begin
          state_d     = S_GAP;
          rsp_valid_d = 1'b1;
        end else begin
          tmr_d = tmr_q - CW'(1);
        end
      end
      S_WAIT_READ: begin
        sc_cmd_d = CMD_READ;
        sc_id_d  = sc_id_q;
        rvalid_d = sc_valid_data_out_i;
        rdata_d  = sc_valid_data_out_i ? sc_rdata_out_i : '0;
        if (sc_valid_data_out_i && sc_last_i) begin
          state_d     = S_GAP;
          sc_cmd_d    = CMD_NONE;
          sc_id_d     = '0;
          rlast_d     = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_ok_d    = 1'b1;
        end else if (tmr_q == '0) begin
          state_d     = S_GAP;
          sc_cmd_d    = CMD_NONE;
          sc_id_d     = '0;
          rsp_valid_d = 1'b1;
        end else begin
          tmr_d = tmr_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cmd_q       <= '0;
      rej_q       <= 1'b0;
      tmr_q       <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b0;
      alloc_q     <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      sc_cmd_q    <= CMD_NONE;
      sc_id_q     <= '0;
      sc_size_q   <= '0;
      sc_data_q   <= '0;
      sc_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cmd_q       <= cmd_d;
      rej_q       <= rej_d;
      tmr_q       <= tmr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ok_q    <= rsp_ok_d;
      alloc_q     <= alloc_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      sc_cmd_q    <= sc_cmd_d;
      sc_id_q     <= sc_id_d;
      sc_size_q   <= sc_size_d;
      sc_data_q   <= sc_data_d;
      sc_vld_q    <= sc_vld_d;
    end
  end

  assign req_if.gnt             = gnt_q;
  assign req_if.rsp_valid       = rsp_valid_q;
  assign req_if.rsp_owner       = owner_q;
  assign req_if.rsp_ok          = rsp_ok_q;
  assign req_if.rsp_alloc_id    = alloc_q;
  assign req_if.rsp_rdata       = rdata_q;
  assign req_if.rsp_rdata_valid = rvalid_q;
  assign req_if.rsp_rdata_last  = rlast_q;
  assign sc_command_in_o        = sc_cmd_q;
  assign sc_id_o                = sc_id_q;
  assign sc_new_counter_size_o  = sc_size_q;
  assign sc_load_data_in_o      = sc_data_q;
  assign sc_valid_load_data_o   = sc_vld_q;
endmodule

// File: tb/tb_shared_counters_sched.sv
// Directed bench for shared_counters_sched; the shared_counters responses
// (allocation ids, read beats) are driven by hand from the stimulus.
module tb_shared_counters_sched;
  localparam int N = 10, G = 4, NREQ = 4, ALLOC_WAIT = 8, READ_WAIT = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shared_counters_sched_if #(.N(N), .G(G), .NREQ(NREQ)) bus ();

  logic [2:0]  sc_cmd;
  logic [3:0]  sc_id;
  logic [31:0] sc_size;
  logic [63:0] sc_data;
  logic        sc_vld;
  logic [4:0]  sc_aid;
  logic        sc_aval;
  logic [3:0]  sc_rdata;
  logic        sc_rv;
  logic        sc_last;

  shared_counters_sched #(.N(N), .G(G), .NREQ(NREQ), .ALLOC_WAIT(ALLOC_WAIT),
                          .READ_WAIT(READ_WAIT)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .req_if                   (bus),
    .sc_command_in_o          (sc_cmd),
    .sc_id_o                  (sc_id),
    .sc_new_counter_size_o    (sc_size),
    .sc_load_data_in_o        (sc_data),
    .sc_valid_load_data_o     (sc_vld),
    .sc_allocation_id_i       (sc_aid),
    .sc_valid_allocation_id_i (sc_aval),
    .sc_rdata_out_i           (sc_rdata),
    .sc_valid_data_out_i      (sc_rv),
    .sc_last_i                (sc_last)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic [2:0] cmd, input logic [3:0] id,
                         input logic [4:0] size, input logic [63:0] data);
    bus.req_cmd[3*c +: 3]        = cmd;
    bus.req_id[4*c +: 4]         = id;
    bus.req_size[5*c +: 5]       = size;
    bus.req_load_data[64*c +: 64] = data;
    bus.req[c]                   = 1'b1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.req = '0; bus.req_cmd = '0; bus.req_id = '0; bus.req_size = '0; bus.req_load_data = '0;
    sc_aid = '0; sc_aval = 1'b0; sc_rdata = '0; sc_rv = 1'b0; sc_last = 1'b0;
    step();
    step();
    chk("rst_gnt", 64'(bus.gnt), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_sc_cmd", 64'(sc_cmd), 64'h0);
    rst = 1'b0;

    // new size 3, allocation id returned two cycles after issue
    set_req(0, 3'b010, 4'd0, 5'd3, 64'h0);
    step();
    chk("new_gnt", 64'(bus.gnt), 64'h1);
    chk("new_cmd", 64'(sc_cmd), 64'h2);
    chk("new_size", 64'(sc_size), 64'd3);
    bus.req[0] = 1'b0;
    step();
    chk("new_gnt_once", 64'(bus.gnt), 64'h0);
    chk("new_cmd_once", 64'(sc_cmd), 64'h0);
    step();
    chk("new_wait_rsp", 64'(bus.rsp_valid), 64'h0);
    sc_aval = 1'b1; sc_aid = 5'd0;
    step();
    sc_aval = 1'b0;
    chk("new_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("new_rsp_ok", 64'(bus.rsp_ok), 64'h1);
    chk("new_alloc_id", 64'(bus.rsp_alloc_id), 64'h0);
    chk("new_owner", 64'(bus.rsp_owner), 64'h0);

    // all four clients increment; pointer reset so order is 0,1,2,3
    do_reset();
    for (int c = 0; c < 4; c++) set_req(c, 3'b001, 4'(c + 1), 5'd0, 64'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_gnt", 64'(bus.gnt), 64'(4'b0001 << k));
      chk("rr_cmd", 64'(sc_cmd), 64'h1);
      chk("rr_id", 64'(sc_id), 64'(k + 1));
      bus.req[k] = 1'b0;
      step();
      chk("rr_gap_cmd", 64'(sc_cmd), 64'h0);
      chk("rr_rsp_valid", 64'(bus.rsp_valid), 64'h1);
      chk("rr_rsp_ok", 64'(bus.rsp_ok), 64'h1);
      chk("rr_owner", 64'(bus.rsp_owner), 64'(k));
    end

    // client 2 reads id 0, three beats
    set_req(2, 3'b101, 4'd0, 5'd0, 64'h0);
    step();
    chk("rd_gnt", 64'(bus.gnt), 64'h4);
    chk("rd_cmd_issue", 64'(sc_cmd), 64'h5);
    bus.req[2] = 1'b0;
    step();
    chk("rd_cmd_wait", 64'(sc_cmd), 64'h5);
    sc_rv = 1'b1; sc_rdata = 4'b1010; sc_last = 1'b0;
    step();
    chk("rd_b1_data", 64'(bus.rsp_rdata), 64'hA);
    chk("rd_b1_valid", 64'(bus.rsp_rdata_valid), 64'h1);
    chk("rd_b1_owner", 64'(bus.rsp_owner), 64'h2);
    chk("rd_b1_rsp", 64'(bus.rsp_valid), 64'h0);
    sc_rdata = 4'b0101;
    step();
    chk("rd_b2_data", 64'(bus.rsp_rdata), 64'h5);
    chk("rd_b2_last", 64'(bus.rsp_rdata_last), 64'h0);
    chk("rd_b2_cmd", 64'(sc_cmd), 64'h5);
    sc_rdata = 4'b1111; sc_last = 1'b1;
    step();
    sc_rv = 1'b0; sc_last = 1'b0; sc_rdata = '0;
    chk("rd_b3_data", 64'(bus.rsp_rdata), 64'hF);
    chk("rd_b3_last", 64'(bus.rsp_rdata_last), 64'h1);
    chk("rd_b3_rsp", 64'(bus.rsp_valid), 64'h1);
    chk("rd_b3_ok", 64'(bus.rsp_ok), 64'h1);
    chk("rd_gap_cmd", 64'(sc_cmd), 64'h0);
    step();
    chk("rd_idle_valid", 64'(bus.rsp_rdata_valid), 64'h0);

    // client 1 load
    set_req(1, 3'b100, 4'd0, 5'd0, 64'hAAAA_AAAA_AAAA_AAAA);
    step();
    chk("ld_gnt", 64'(bus.gnt), 64'h2);
    chk("ld_cmd", 64'(sc_cmd), 64'h4);
    chk("ld_vld", 64'(sc_vld), 64'h1);
    chk("ld_data", sc_data, 64'hAAAA_AAAA_AAAA_AAAA);
    bus.req[1] = 1'b0;
    step();
    chk("ld_gap_cmd", 64'(sc_cmd), 64'h0);
    chk("ld_gap_vld", 64'(sc_vld), 64'h0);
    chk("ld_gap_data", sc_data, 64'h0);
    chk("ld_rsp_ok", 64'(bus.rsp_ok), 64'h1);

    // client 0 new with no allocation response: pointer 2 wraps to 0
    set_req(0, 3'b010, 4'd1, 5'd2, 64'h0);
    step();
    chk("to_gnt", 64'(bus.gnt), 64'h1);
    bus.req[0] = 1'b0;
    for (int j = 1; j <= ALLOC_WAIT + 1; j++) begin
      step();
      chk("to_early_rsp", 64'(bus.rsp_valid), 64'h0);
    end
    step();
    chk("to_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("to_rsp_ok", 64'(bus.rsp_ok), 64'h0);
    chk("to_alloc_id", 64'(bus.rsp_alloc_id), 64'h0);

    // client 3 illegal cmd 111
    set_req(3, 3'b111, 4'd2, 5'd0, 64'h0);
    step();
    chk("ill_gnt", 64'(bus.gnt), 64'h8);
    chk("ill_cmd", 64'(sc_cmd), 64'h0);
    bus.req[3] = 1'b0;
    step();
    chk("ill_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("ill_rsp_ok", 64'(bus.rsp_ok), 64'h0);
    chk("ill_owner", 64'(bus.rsp_owner), 64'h3);

    // client 2 new with size 0 is rejected locally
    set_req(2, 3'b010, 4'd3, 5'd0, 64'h0);
    step();
    chk("sz0_gnt", 64'(bus.gnt), 64'h4);
    chk("sz0_cmd", 64'(sc_cmd), 64'h0);
    bus.req[2] = 1'b0;
    step();
    chk("sz0_rsp_ok", 64'(bus.rsp_ok), 64'h0);
    chk("sz0_rsp_valid", 64'(bus.rsp_valid), 64'h1);

    // pointer at 3: client 3 beats client 0, then 0 is served
    set_req(0, 3'b001, 4'd5, 5'd0, 64'h0);
    set_req(3, 3'b011, 4'd7, 5'd0, 64'h0);
    step();
    chk("pri_gnt3", 64'(bus.gnt), 64'h8);
    chk("pri_cmd3", 64'(sc_cmd), 64'h3);
    bus.req[3] = 1'b0;
    step();
    step();
    chk("pri_gnt0", 64'(bus.gnt), 64'h1);
    chk("pri_id0", 64'(sc_id), 64'd5);
    bus.req[0] = 1'b0;
    step();
    chk("pri_owner0", 64'(bus.rsp_owner), 64'h0);

    // read aborted by reset; pointer returns to 0
    set_req(2, 3'b101, 4'd4, 5'd0, 64'h0);
    step();
    chk("ab_gnt", 64'(bus.gnt), 64'h4);
    bus.req[2] = 1'b0;
    step();
    sc_rv = 1'b1; sc_rdata = 4'b1010;
    step();
    chk("ab_b1_valid", 64'(bus.rsp_rdata_valid), 64'h1);
    sc_rv = 1'b0; sc_rdata = '0;
    rst = 1'b1;
    set_req(1, 3'b001, 4'd3, 5'd0, 64'h0);
    set_req(3, 3'b001, 4'd6, 5'd0, 64'h0);
    step();
    chk("ab_gnt_rst", 64'(bus.gnt), 64'h0);
    chk("ab_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("ab_rdata_valid", 64'(bus.rsp_rdata_valid), 64'h0);
    chk("ab_sc_cmd", 64'(sc_cmd), 64'h0);
    chk("ab_sc_id", 64'(sc_id), 64'h0);
    rst = 1'b0;
    step();
    chk("ab_post_gnt", 64'(bus.gnt), 64'h2);
    chk("ab_post_id", 64'(sc_id), 64'd3);
    bus.req[1] = 1'b0;
    step();
    chk("ab_post_rsp", 64'(bus.rsp_valid), 64'h1);
    chk("ab_post_owner", 64'(bus.rsp_owner), 64'h1);
    step();
    chk("ab_next_gnt", 64'(bus.gnt), 64'h8);
    chk("ab_next_id", 64'(sc_id), 64'd6);
    bus.req[3] = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shared_counters_sched.md
Name: shared_counters_sched

Overview:
- Multi-requester command scheduler in front of shared_counters; the only block that drives shared_counters' command interface.
- Arbitrates NREQ clients round-robin and issues one shared_counters command at a time.
- Sequences each command's timing: one-cycle pulses, allocation wait, multi-beat read, trailing idle cycle.
- Returns a per-command response (status, allocation id, read beats) tagged with the owning requester.

Parameters:
N, 10, counter slices in shared_counters (same as its n)
G, 4, slice width (same as its g)
NREQ, 4, number of requesters (>=2)
ALLOC_WAIT, 8, max cycles after issue to wait for valid_allocation_id
READ_WAIT, 32, max cycles in read phase to wait for last beat

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req  in  NREQ  request per client; held with payload until gnt
req_cmd  in  3*NREQ  per-client command code (001 inc, 010 new, 011 dealloc, 100 load, 101 read)
req_id  in  $clog2(N)*NREQ  per-client counter id
req_size  in  ($clog2(N)+1)*NREQ  per-client new-counter size in slices
req_load_data  in  64*NREQ  per-client load value
gnt  out  NREQ  one-hot, one-cycle acceptance pulse
rsp_valid  out  1  one-cycle command completion pulse
rsp_owner  out  $clog2(NREQ)  requester of current response/beat
rsp_ok  out  1  1=success, 0=fail; valid with rsp_valid
rsp_alloc_id  out  $clog2(N)+1  allocation id; valid with rsp_valid on ok new
rsp_rdata  out  G  forwarded read beat
rsp_rdata_valid  out  1  read beat valid
rsp_rdata_last  out  1  final read beat
sc_command_in  out  3  to shared_counters command_in
sc_id  out  $clog2(N)  to shared_counters id
sc_new_counter_size  out  32  zero-extended size
sc_load_data_in  out  64  to load_data_in
sc_valid_load_data  out  1  to valid_load_data
sc_allocation_id  in  $clog2(N)+1  from shared_counters
sc_valid_allocation_id  in  1  from shared_counters
sc_rdata_out  in  G  from rdata_out
sc_valid_data_out  in  1  from valid_data_out
sc_last  in  1  from last

Behaviour:
- All outputs are registered. On rst every output is 0, sc_command_in=000, state=IDLE, rr pointer=0. Reset mid-operation aborts the in-flight command with no response.
- States: IDLE, ISSUE, WAIT_ALLOC, WAIT_READ, GAP.
- Arbitration is evaluated at any edge where state is IDLE or GAP and req!=0.
  - Winner is the first asserted req at or after the pointer, wrapping.
  - The winner's payload is captured; the pointer becomes (winner+1)%NREQ.
  - gnt[winner]=1 for exactly the next cycle (the ISSUE cycle). Requests are ignored in all other states.
- ISSUE: sc_command_in=cmd and sc_id=id. For new, sc_new_counter_size=size. For load, sc_load_data_in=data and sc_valid_load_data=1.
- Transitions out of ISSUE:
  - inc/dealloc/load: to GAP, with rsp_valid=1 and rsp_ok=1 in the GAP cycle.
  - new: to WAIT_ALLOC.
  - read: to WAIT_READ.
- WAIT_ALLOC:
  - sc_command_in=000.
  - On sc_valid_allocation_id: capture sc_allocation_id; next cycle is GAP with rsp_valid=1, rsp_ok=1, rsp_alloc_id=captured.
  - After ALLOC_WAIT cycles with no valid: GAP with rsp_ok=0, rsp_alloc_id=0.
  - sc_valid_allocation_id seen on the ISSUE cycle counts.
- WAIT_READ:
  - sc_command_in stays 101 through ISSUE and WAIT_READ.
  - Each sc_valid_data_out beat is forwarded one cycle later on rsp_rdata/rsp_rdata_valid/rsp_rdata_last, with rsp_owner set.
  - On valid&&last: next cycle is GAP, sc_command_in=000, and the last beat appears with rsp_valid=1, rsp_ok=1.
  - READ_WAIT cycles without last: GAP with rsp_ok=0, and no rsp_rdata_last.
- GAP: sc_command_in=000 for exactly one cycle. Minimum command spacing is therefore 2 cycles; a read occupies at least 3.
- Local rejects: cmd 000/110/111, or new with size=0.
  - The request is still granted (gnt pulses) but nothing is driven downstream.
  - The next cycle is GAP with rsp_valid=1, rsp_ok=0.
- Timeout counters are sized to fit ALLOC_WAIT and READ_WAIT and clear on entering each wait state.
- Simultaneous arbitration win and rst: rst wins.

Test Plan:
- Reset, then req=0001 new size 3 with model asserting valid_allocation_id=0 two cycles after ISSUE -> gnt=0001 one cycle; sc_command_in=010 for one cycle with size 3; then rsp_valid, rsp_ok=1, rsp_alloc_id=0, rsp_owner=0.
- req=1111 all increments, held -> grants in order 0,1,2,3 on every other cycle; sc_command_in alternates 001/000; sc_id follows each client; 4 rsp_ok=1 pulses.
- Client 2 read id 0, model returns 3 beats 1010,0101,1111 with last on beat 3 -> sc_command_in=101 until the cycle after last; 3 forwarded beats, owner 2; rsp_valid and rsp_rdata_last on beat 3.
- Client 1 load id 0, data 0xAAAA_AAAA_AAAA_AAAA -> one cycle with sc_command_in=100, sc_valid_load_data=1 and that data; all zero after.
- Client 0 new with no allocation response -> rsp_ok=0 exactly ALLOC_WAIT+2 cycles after gnt. Client 3 cmd 111 -> gnt, no downstream command, rsp_ok=0.
- Read in progress (beat 1 forwarded) then rst for 1 cycle -> all outputs 0 the next cycle, no rsp_valid; a subsequent req=0010 is granted to client 1 (pointer reset).
